// File: rtl/axil_reg_pkg.sv
// Shared constants for the AXI4-Lite register slave: address offsets,
// response codes and the byte-strobe merge helper.
package axil_reg_pkg;

  localparam logic [11:0] ADDR_ID     = 12'h020;
  localparam logic [11:0] ADDR_WR_CNT = 12'h024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word indices (address bits [11:2]) of the read-only registers.
  localparam logic [9:0] ID_WORD     = ADDR_ID[11:2];
  localparam logic [9:0] WR_CNT_WORD = ADDR_WR_CNT[11:2];

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle matching the axil_reg_slave port set.
interface axil_reg_slave_if;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  // Every channel transfers on a clock edge where valid && ready; a source
  // keeps valid and payload stable until that edge and never waits on ready.
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_skid_slot.sv
// One-entry holding buffer: accepts a payload when empty, keeps it until
// the owner pulses clear.
module axil_skid_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] payload,
  input  logic         clear,
  output logic         full,
  output logic [W-1:0] held
);

  assign ready = ~full;

  // clear is only raised while full, so it never collides with a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      held <= '0;
    end else if (valid && ready) begin
      full <= 1'b1;
      held <= payload;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: NUM_RW byte-strobed RW registers, a constant ID
// register and a count of successful writes.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int          NUM_RW   = 8,
  parameter logic [31:0] ID_VALUE = 32'h5250_0001
) (
  input  logic        reg_clk,
  input  logic        reg_rst,
  input  logic [11:0] s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [11:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready
);

  localparam logic [9:0] RW_WORDS = 10'(NUM_RW);

  logic        aw_full;
  logic        w_full;
  logic [9:0]  aw_word;
  logic [35:0] w_held;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        commit;
  logic        wr_is_rw;
  logic [31:0] rw_regs [NUM_RW];
  logic [31:0] wr_cnt;
  logic [9:0]  ar_word;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // A commit waits for both halves and for any earlier response to drain.
  assign commit   = aw_full && w_full && !s_axil_bvalid;
  assign wr_is_rw = aw_word < RW_WORDS;
  assign w_data   = w_held[31:0];
  assign w_strb   = w_held[35:32];

  axil_skid_slot #(.W(10)) u_aw_slot (
    .clk     (reg_clk),
    .rst     (reg_rst),
    .valid   (s_axil_awvalid),
    .ready   (s_axil_awready),
    .payload (s_axil_awaddr[11:2]),
    .clear   (commit),
    .full    (aw_full),
    .held    (aw_word)
  );

  axil_skid_slot #(.W(36)) u_w_slot (
    .clk     (reg_clk),
    .rst     (reg_rst),
    .valid   (s_axil_wvalid),
    .ready   (s_axil_wready),
    .payload ({s_axil_wstrb, s_axil_wdata}),
    .clear   (commit),
    .full    (w_full),
    .held    (w_held)
  );

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      for (int i = 0; i < NUM_RW; i++) rw_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (commit && wr_is_rw && aw_word == 10'(i))
          rw_regs[i] <= apply_strb(rw_regs[i], w_data, w_strb);
      end
    end
  end

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      wr_cnt        <= '0;
    end else if (commit) begin
      s_axil_bvalid <= 1'b1;
      s_axil_bresp  <= wr_is_rw ? RESP_OKAY : RESP_SLVERR;
      if (wr_is_rw) wr_cnt <= wr_cnt + 32'd1;
    end else if (s_axil_bvalid && s_axil_bready) begin
      s_axil_bvalid <= 1'b0;
    end
  end

  assign ar_word        = s_axil_araddr[11:2];
  assign s_axil_arready = ~s_axil_rvalid;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_RW; i++) begin
      if (ar_word == 10'(i)) begin
        rd_data = rw_regs[i];
        rd_resp = RESP_OKAY;
      end
    end
    if (ar_word == ID_WORD) begin
      rd_data = ID_VALUE;
      rd_resp = RESP_OKAY;
    end else if (ar_word == WR_CNT_WORD) begin
      rd_data = wr_cnt;
      rd_resp = RESP_OKAY;
    end
  end

  // Registers sample rw_regs before the same-edge commit lands.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else if (s_axil_arvalid && s_axil_arready) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_data;
      s_axil_rresp  <= rd_resp;
    end else if (s_axil_rvalid && s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter NUM_RW, default 8, number of read/write 32-bit registers mapped at 0x000 up to 4*(NUM_RW-1), range 1..8.
REQ-002 SHALL have parameter ID_VALUE, default 32'h5250_0001, constant returned by the read-only ID register at 0x020.
REQ-003 SHALL have port reg_clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reg_rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have write-address ports: s_axil_awaddr in 12, s_axil_awvalid in 1, s_axil_awready out 1.
REQ-006 SHALL have write-data ports: s_axil_wdata in 32, s_axil_wstrb in 4, s_axil_wvalid in 1, s_axil_wready out 1.
REQ-007 SHALL have write-response ports: s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1.
REQ-008 SHALL have read ports: s_axil_araddr in 12, s_axil_arvalid in 1, s_axil_arready out 1, s_axil_rdata out 32, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1.

Function
REQ-009 SHALL use this address map: RW registers 0x000..4*(NUM_RW-1); ID at 0x020 (RO); WR_CNT at 0x024 (RO); all other addresses unmapped.
REQ-010 SHALL decode addresses on awaddr/araddr[11:2]; bits [1:0] are ignored.
REQ-011 SHALL drive awready high exactly when the AW holding buffer is empty; an AW handshake fills the buffer with the address.
REQ-012 SHALL drive wready high exactly when the W holding buffer is empty; a W handshake fills the buffer with data and strobe.
REQ-013 SHALL accept AW and W independently, in either order or in the same cycle.
REQ-014 SHALL commit a write on the first clock edge at which both buffers are full and bvalid is low; this commit clears both buffers and sets bvalid.
REQ-015 SHALL therefore assert bvalid exactly one cycle after the later of the AW and W handshakes when no response is pending.
REQ-016 SHALL, at commit to an RW register, update only the bytes whose wstrb bit is set; wstrb=0 writes nothing but still responds OKAY.
REQ-017 SHALL respond bresp=2'b00 (OKAY) for RW addresses, and 2'b10 (SLVERR) for ID, WR_CNT or unmapped addresses, with no state change.
REQ-018 SHALL increment WR_CNT by 1 on every OKAY commit, wrapping 0xFFFF_FFFF to 0.
REQ-019 SHALL hold bvalid and bresp stable until bready; bvalid falls on the bvalid&&bready edge.
REQ-020 SHALL allow a further AW/W to be accepted while bvalid is pending; its commit waits until the edge after the pending response completes.
REQ-021 SHALL drive arready = ~rvalid.
REQ-022 SHALL, on an AR handshake, register rdata and rresp and assert rvalid on the next cycle (latency 1).
REQ-023 SHALL hold rdata, rresp and rvalid stable until rready.
REQ-024 SHALL return rresp OKAY with data for RW, ID and WR_CNT reads, and SLVERR with rdata=0 for unmapped addresses.
REQ-025 SHALL, when a read handshake and a write commit to the same register occur on the same edge, return the pre-commit value.

Reset
REQ-026 SHALL, while reg_rst is high, force: all RW registers and WR_CNT to 0; buffers empty; bvalid, rvalid and rdata low; bresp and rresp 2'b00; awready and wready high; arready high.
REQ-027 SHALL discard any partially buffered or pending transaction on reset, including one asserted mid-operation, with no register update.

Structure
REQ-028 SHALL place the address offsets (ID 0x020, WR_CNT 0x024) and the response codes OKAY/SLVERR in the shared axil_reg_pkg package.
REQ-029 SHALL instantiate one sub-module, axil_skid_slot, used twice for the AW and W holding buffers (valid/ready in, full flag plus payload out).

Verification
REQ-030 SHALL cover: AW 0x004 and W 0xA5A5_5A5A/strb 0xF in the same cycle, then read 0x004 -> bvalid one cycle later with OKAY; read returns 0xA5A5_5A5A with OKAY.
REQ-031 SHALL cover: W data 0x1122_3344 issued 3 cycles before AW 0x000 -> wready low until commit; bvalid one cycle after the AW handshake; reg0 = 0x1122_3344.
REQ-032 SHALL cover: strb 4'b0101 with data 0xFFFF_FFFF over reg1 = 0 -> reg1 = 0x00FF_00FF; WR_CNT read = 1.
REQ-033 SHALL cover: write 0x020, then read 0x100 -> bresp SLVERR with ID unchanged (reads 0x5250_0001); rresp SLVERR with rdata 0.
REQ-034 SHALL cover: bready held low for 5 cycles while a second AW/W pair is sent -> the second pair is accepted, the second bvalid appears one cycle after the first response completes, and WR_CNT = 2.
REQ-035 SHALL cover: reg_rst asserted after the AW handshake and before W -> all outputs at their reset values; a subsequent W alone produces no bvalid.
